// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b cache typedefs, geometry and the cache FSM state enum
package lc3b_types;
  typedef logic [8:0] lc3b_tag;
  typedef logic [2:0] lc3b_index;
  typedef logic [2:0] lc3b_offset3;
  typedef logic [1:0] lc3b_mem_wmask;
  typedef logic lc3b_way;
  localparam int NUM_SETS = 2 ** $bits(lc3b_index);
  localparam int WORDS_PER_BLOCK = 2 ** $bits(lc3b_offset3);
  typedef logic [16*WORDS_PER_BLOCK-1:0] lc3b_block;
  typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC} lc3b_cache_state;
endpackage

// File: rtl/cache_array.sv
// cache_array: NUM_SETS x W store, async read, sync write and clear; ports clk, rst, we, idx, din, dout
module cache_array
  import lc3b_types::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [2:0]   idx,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] mem_q [NUM_SETS];
  logic [W-1:0] mem_d [NUM_SETS];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = din;
  end
  always_ff @(posedge clk)
    if (rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  assign dout = mem_q[idx];
endmodule

// File: rtl/l1_cache_2way.sv
// l1_cache_2way: 2-way write-back/write-allocate LC-3b L1 cache; ports clk, reset, CPU mem_* (16-bit), pmem_* (128-bit blocks); `L1_CACHE_PERF_EN adds hit_count/miss_count
module l1_cache_2way
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef L1_CACHE_PERF_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);
  lc3b_cache_state state_q, state_d;
  lc3b_tag req_tag;
  lc3b_tag tag_o [2];
  lc3b_index idx;
  lc3b_offset3 off;
  lc3b_block data_o [2];
  lc3b_block hit_line, wr_line, data_din;
  logic [1:0] valid_o, dirty_o, hits, we;
  logic req, hit, fill, idle_hit, lru_o, unused_byte_sel;
  lc3b_way hit_way, victim;
  logic [15:0] old_word;
  assign req_tag = mem_address[15:7];
  assign idx = mem_address[6:4];
  assign off = mem_address[3:1];
  assign unused_byte_sel = mem_address[0];
  assign req = mem_read | mem_write;
  assign hits = {valid_o[1] && tag_o[1] == req_tag, valid_o[0] && tag_o[0] == req_tag};
  assign hit = |hits;
  assign hit_way = hits[1];
  assign victim = lru_o;
  assign fill = state_q == S_ALLOC && pmem_resp;
  assign idle_hit = state_q == S_IDLE && req && hit;
  assign hit_line = data_o[hit_way];
  assign old_word = hit_line[{off, 4'b0} +: 16];
  always_comb begin
    wr_line = hit_line;
    wr_line[{off, 4'b0} +: 16] = {mem_byte_enable[1] ? mem_wdata[15:8] : old_word[15:8],
                                  mem_byte_enable[0] ? mem_wdata[7:0] : old_word[7:0]};
  end
  // One write port per way serves both CPU write hits and block fills; a fill always lands clean.
  assign data_din = fill ? pmem_rdata : wr_line;
  for (genvar w = 0; w < 2; w++) begin : g_way
    assign we[w] = (idle_hit && mem_write && hit_way == lc3b_way'(w)) || (fill && victim == lc3b_way'(w));
    cache_array #(.W(128)) u_data (.clk, .rst(reset), .we(we[w]), .idx, .din(data_din), .dout(data_o[w]));
    cache_array #(.W(9)) u_tag (.clk, .rst(reset), .we(we[w]), .idx, .din(req_tag), .dout(tag_o[w]));
    cache_array #(.W(1)) u_valid (.clk, .rst(reset), .we(we[w]), .idx, .din(1'b1), .dout(valid_o[w]));
    cache_array #(.W(1)) u_dirty (.clk, .rst(reset), .we(we[w]), .idx, .din(!fill), .dout(dirty_o[w]));
  end
  cache_array #(.W(1)) u_lru (.clk, .rst(reset), .we(idle_hit), .idx, .din(~hit_way), .dout(lru_o));
  assign mem_rdata = reset ? '0 : old_word;
  assign mem_resp = !reset && idle_hit;
  assign pmem_read = state_q == S_ALLOC;
  assign pmem_write = state_q == S_WB;
  assign pmem_address = reset ? '0 : {state_q == S_WB ? tag_o[victim] : req_tag, idx, 4'b0};
  assign pmem_wdata = reset ? '0 : data_o[victim];
  always_comb
    state_d = state_q == S_IDLE ? (req && !hit ? (valid_o[victim] && dirty_o[victim] ? S_WB : S_ALLOC) : S_IDLE)
            : state_q == S_WB ? (pmem_resp ? S_ALLOC : S_WB)
            : state_q == S_ALLOC ? (pmem_resp ? S_IDLE : S_ALLOC)
            : S_IDLE;
  always_ff @(posedge clk) state_q <= reset ? S_IDLE : state_d;
`ifdef L1_CACHE_PERF_EN
  logic [15:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic fill_done_q, fill_done_d;
  // The hit right after a fill completes the original miss, so it is not a new hit.
  always_comb begin
    fill_done_d = fill;
    hit_count_d = hit_count_q + 16'(idle_hit && !fill_done_q && hit_count_q != 16'hFFFF);
    miss_count_d = miss_count_q + 16'(state_q == S_IDLE && req && !hit && miss_count_q != 16'hFFFF);
  end
  always_ff @(posedge clk)
    if (reset) begin
      hit_count_q <= '0;
      miss_count_q <= '0;
      fill_done_q <= 1'b0;
    end else begin
      hit_count_q <= hit_count_d;
      miss_count_q <= miss_count_d;
      fill_done_q <= fill_done_d;
    end
  assign hit_count = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule
